// File: rtl/rv32_register_file_if.sv
// Operand-fetch / writeback bus of the RV32I register file.
// The master (decode/writeback) drives indices and write data; the slave (register file) returns read data.
interface rv32_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x 32-bit registers, x0 hardwired to zero, two combinational reads, one synchronous write.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module rv32_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input logic                  clk,
  input logic                  reset,
  rv32_register_file_if.slave  rf
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  writeEn;

  // Writes to x0 are dropped here, so entry 0 stays zero after the first reset.
  assign writeEn = rf.reg_write && (rf.write_reg != '0);

  always_comb begin
    regs_d = regs_q;
    if (writeEn) begin
      regs_d[rf.write_reg] = rf.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index 0 is forced to zero on read as well, so x0 never depends on storage contents.
  always_comb begin
    rf.read_data1 = '0;
    rf.read_data2 = '0;
    if (rf.read_reg1 != '0) begin
      rf.read_data1 = regs_q[rf.read_reg1];
    end
    if (rf.read_reg2 != '0) begin
      rf.read_data2 = regs_q[rf.read_reg2];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (writeEn && !reset && (rf.write_reg == rf.read_reg1)) begin
      rf.read_data1 = rf.write_data;
    end
    if (writeEn && !reset && (rf.write_reg == rf.read_reg2)) begin
      rf.read_data2 = rf.write_data;
    end
`endif
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed testbench for rv32_register_file; expectations are hand-computed constants.
// Read-during-write expectations depend on REGFILE_WRITE_BYPASS_EN.
module tb_rv32_register_file;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  rv32_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rfIf ();

  rv32_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rfIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Drives one set of bus inputs and lets the combinational reads settle.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2);
    reset           = rst;
    rfIf.reg_write  = we;
    rfIf.write_reg  = waddr;
    rfIf.write_data = wdata;
    rfIf.read_reg1  = r1;
    rfIf.read_reg2  = r2;
    #1;
  endtask

  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rdwExpected;
    checkCount = 0;
    errorCount = 0;
`ifdef REGFILE_WRITE_BYPASS_EN
    rdwExpected = 32'h2222_2222;
`else
    rdwExpected = 32'h1111_1111;
`endif

    // Reset for two edges with a write pending, which must be discarded.
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h5555_5555, 5'd0, 5'd31);
    tickClock();
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
    checkOutput("reset_rd1_x0", rfIf.read_data1, 32'h0);
    checkOutput("reset_rd2_x31", rfIf.read_data2, 32'h0);
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, i[4:0], 5'd0);
      checkOutput($sformatf("reset_x%0d", i), rfIf.read_data1, 32'h0);
    end

    // Basic write of x1.
    applyStimulus(1'b0, 1'b1, 5'd1, 32'haaaa_bbbb, 5'd1, 5'd0);
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd1, 32'haaaa_bbbb, 5'd1, 5'd0);
    checkOutput("write_x1", rfIf.read_data1, 32'haaaa_bbbb);
    checkOutput("write_x1_rd2_x0", rfIf.read_data2, 32'h0);

    // x0 protection, including the same-cycle read of x0 while it is targeted.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hffff_ffff, 5'd0, 5'd1);
    checkOutput("x0_pre_edge", rfIf.read_data1, 32'h0);
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'hffff_ffff, 5'd0, 5'd1);
    checkOutput("x0_post_edge", rfIf.read_data1, 32'h0);
    checkOutput("x1_unchanged", rfIf.read_data2, 32'haaaa_bbbb);

    // Write enable gating.
    applyStimulus(1'b0, 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    tickClock();
    checkOutput("gated_x5", rfIf.read_data1, 32'h0);

    // Dual-port reads of two distinct registers, then both ports on one register.
    applyStimulus(1'b0, 1'b1, 5'd31, 32'hdead_beef, 5'd0, 5'd0);
    tickClock();
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h0bad_f00d, 5'd0, 5'd0);
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd2);
    checkOutput("dual_rd1_x31", rfIf.read_data1, 32'hdead_beef);
    checkOutput("dual_rd2_x2", rfIf.read_data2, 32'h0bad_f00d);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    checkOutput("same_rd1_x31", rfIf.read_data1, 32'hdead_beef);
    checkOutput("same_rd2_x31", rfIf.read_data2, 32'hdead_beef);
    checkOutput("x1_still", dut.regs_q[1], 32'haaaa_bbbb);

    // Read-during-write on x3 from both ports.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
    tickClock();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd3);
    checkOutput("rdw_pre_rd1", rfIf.read_data1, rdwExpected);
    checkOutput("rdw_pre_rd2", rfIf.read_data2, rdwExpected);
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h2222_2222, 5'd3, 5'd2);
    checkOutput("rdw_post_rd1", rfIf.read_data1, 32'h2222_2222);
    checkOutput("rdw_post_rd2_x2", rfIf.read_data2, 32'h0bad_f00d);

    // Reset mid-operation beats a simultaneous write; pre-edge reads still show old data.
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hcafe_f00d, 5'd1, 5'd4);
    checkOutput("rstpri_pre_x1", rfIf.read_data1, 32'haaaa_bbbb);
    checkOutput("rstpri_pre_x4", rfIf.read_data2, 32'h0);
    tickClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd4);
    checkOutput("rstpri_post_x1", rfIf.read_data1, 32'h0);
    checkOutput("rstpri_post_x4", rfIf.read_data2, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd3);
    checkOutput("rstpri_post_x31", rfIf.read_data1, 32'h0);
    checkOutput("rstpri_post_x3", rfIf.read_data2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
